// File: rtl/gram_matrix_streamer.sv
// gram_matrix_streamer: double-buffered 4x4 Gram-matrix serializer.
// A whole matrix is loaded in one handshake into the active or pending slot.
// Elements leave one per valid/ready beat, in raster order.
// Optional build macro: GRAM_SYMMETRIC_EN streams only the upper triangle (c >= r), 10 beats.
module gram_matrix_streamer #(
  parameter int unsigned DW = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [16*DW-1:0]  i_ld_matrix,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DW-1:0]     o_out_data,
  output logic [1:0]        o_out_row,
  output logic [1:0]        o_out_col,
  output logic              o_out_last
);

  localparam int unsigned NELEM = 16;

  typedef enum logic [1:0] {
    S_EMPTY       = 2'd0,
    S_STREAM      = 2'd1,
    S_STREAM_PEND = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_active     [NELEM];
  logic [DW-1:0] r_pend       [NELEM];
  logic [DW-1:0] w_active_nxt [NELEM];
  logic [DW-1:0] w_pend_nxt   [NELEM];
  logic [DW-1:0] w_ld_elem    [NELEM];

  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [1:0]    w_row_nxt;
  logic [1:0]    w_col_nxt;
  logic [1:0]    w_row_adv;
  logic [1:0]    w_col_adv;

  logic          w_beat;
  logic          w_final;
  logic          w_load;
  logic          w_valid_nxt;
  logic          w_last_nxt;
  logic [DW-1:0] w_data_nxt;

  // Unpack the flat load bus into elements; element index is 4*r+c.
  for (genvar g = 0; g < 16; g++) begin : g_unpack
`ifdef GRAM_SYMMETRIC_EN
    // Lower-triangle entries are never streamed, so they are not captured.
    if ((g % 4) >= (g / 4)) begin : g_upper
      assign w_ld_elem[g] = i_ld_matrix[g*DW +: DW];
    end else begin : g_lower
      assign w_ld_elem[g] = '0;
    end
`else
    assign w_ld_elem[g] = i_ld_matrix[g*DW +: DW];
`endif
  end

  assign w_beat  = o_out_valid & i_out_ready;
  assign w_final = w_beat & o_out_last;
  assign w_load  = i_ld_valid & o_ld_ready;

  // Next (row, col) after a non-final beat.
  always_comb begin
    w_row_adv = r_row;
    w_col_adv = r_col;
    if (r_col == 2'd3) begin
      w_row_adv = r_row + 2'd1;
`ifdef GRAM_SYMMETRIC_EN
      w_col_adv = r_row + 2'd1;
`else
      w_col_adv = 2'd0;
`endif
    end else begin
      w_col_adv = r_col + 2'd1;
    end
  end

  // Next-state, slot movement and index update.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_pend_nxt   = r_pend;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    case (r_state)
      S_EMPTY: begin
        if (w_load) begin
          w_state_nxt  = S_STREAM;
          w_active_nxt = w_ld_elem;
          w_row_nxt    = 2'd0;
          w_col_nxt    = 2'd0;
        end
      end
      S_STREAM: begin
        if (w_final && w_load) begin
          // New matrix goes straight to active: no bubble between matrices.
          w_active_nxt = w_ld_elem;
          w_row_nxt    = 2'd0;
          w_col_nxt    = 2'd0;
        end else if (w_final) begin
          w_state_nxt = S_EMPTY;
          w_row_nxt   = 2'd0;
          w_col_nxt   = 2'd0;
        end else begin
          if (w_beat) begin
            w_row_nxt = w_row_adv;
            w_col_nxt = w_col_adv;
          end
          if (w_load) begin
            w_state_nxt = S_STREAM_PEND;
            w_pend_nxt  = w_ld_elem;
          end
        end
      end
      S_STREAM_PEND: begin
        if (w_final) begin
          w_state_nxt  = S_STREAM;
          w_active_nxt = r_pend;
          w_row_nxt    = 2'd0;
          w_col_nxt    = 2'd0;
        end else if (w_beat) begin
          w_row_nxt = w_row_adv;
          w_col_nxt = w_col_adv;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Output values as they will appear after the coming edge.
  always_comb begin
    w_valid_nxt = (w_state_nxt != S_EMPTY);
    w_last_nxt  = w_valid_nxt && (w_row_nxt == 2'd3) && (w_col_nxt == 2'd3);
    w_data_nxt  = w_valid_nxt ? w_active_nxt[{w_row_nxt, w_col_nxt}] : '0;
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot buffers, index counters and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NELEM; i++) begin
        r_active[i] <= '0;
        r_pend[i]   <= '0;
      end
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      o_ld_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_row   <= 2'd0;
      o_out_col   <= 2'd0;
      o_out_last  <= 1'b0;
    end else begin
      r_active    <= w_active_nxt;
      r_pend      <= w_pend_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      o_ld_ready  <= (w_state_nxt != S_STREAM_PEND);
      o_out_valid <= w_valid_nxt;
      o_out_data  <= w_data_nxt;
      o_out_row   <= w_row_nxt;
      o_out_col   <= w_col_nxt;
      o_out_last  <= w_last_nxt;
    end
  end

endmodule
